// File: rtl/out_channel_checker.sv
// Out-channel checker: buffers program output words in a small FIFO and compares them,
// in order, against a preloaded expected vector.
module out_channel_checker #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NExpected          = 4,
  parameter int unsigned Depth              = 4,
  parameter int unsigned MaxSteps           = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          exp_we_i,
  input  logic [7:0]                    exp_addr_i,
  input  logic [MemoryElementWidth-1:0] exp_data_i,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  input  logic [MemoryElementWidth-1:0] in_data_i,
  output logic                          in_ready_o,
  input  logic                          hold_i,
  input  logic                          prog_finished_i,
  output logic                          finished_o,
  output logic                          success_o,
  output logic                          mismatch_o,
  output logic                          timeout_o,
  output logic [15:0]                   words_seen_o,
  output logic [15:0]                   first_bad_o
);
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdxW  = (NExpected > 1) ? $clog2(NExpected) : 1;
  localparam int unsigned StepW = $clog2(MaxSteps + 1);

  localparam logic [8:0]       NExpAddr  = 9'(NExpected);
  localparam logic [15:0]      NExpCount = 16'(NExpected);
  localparam logic [CntW-1:0]  DepthCnt  = CntW'(Depth);
  localparam logic [StepW-1:0] StepLimit = StepW'(MaxSteps);

  localparam logic [1:0] StLoad = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [MemoryElementWidth-1:0] exp_mem_q [NExpected];
  logic [MemoryElementWidth-1:0] fifo_q [Depth];
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]               count_q, count_d;
  logic [StepW-1:0]              steps_q, steps_d;
  logic [15:0]                   words_seen_q, words_seen_d, first_bad_q, first_bad_d;
  logic                          mismatch_q, mismatch_d, timeout_q, timeout_d;
  logic                          success_q, success_d;

  logic                          run, fifo_empty, fifo_full, push, pop, word_bad;
  logic [MemoryElementWidth-1:0] pop_data, exp_word;

  assign run        = (state_q == StRun);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);
  assign in_ready_o = run && !fifo_full;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = run && !fifo_empty && !hold_i;
  assign pop_data   = fifo_q[rd_ptr_q];
  assign exp_word   = exp_mem_q[words_seen_q[IdxW-1:0]];
  // Anything past the expected length is a surplus word and always counts as bad.
  assign word_bad   = (words_seen_q >= NExpCount) || (pop_data != exp_word);

  // Expected memory deliberately survives reset so a rerun can reuse it.
  always_ff @(posedge clk_i) begin
    if (state_q == StLoad && exp_we_i && ({1'b0, exp_addr_i} < NExpAddr)) begin
      exp_mem_q[exp_addr_i[IdxW-1:0]] <= exp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    steps_d      = steps_q;
    words_seen_d = words_seen_q;
    first_bad_d  = first_bad_q;
    mismatch_d   = mismatch_q;
    timeout_d    = timeout_q;
    success_d    = success_q;
    case (state_q)
      StLoad: begin
        if (start_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        steps_d = steps_q + 1'b1;
        if (push) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_d     = rd_ptr_q + 1'b1;
          words_seen_d = words_seen_q + 16'd1;
          if (word_bad && !mismatch_q) begin
            mismatch_d  = 1'b1;
            first_bad_d = words_seen_q;
          end
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
        if (prog_finished_i && fifo_empty && !pop) begin
          state_d = StDone;
        end else if (steps_d == StepLimit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
        if (state_d == StDone) begin
          success_d = !mismatch_d && !timeout_d && (words_seen_d == NExpCount);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StLoad;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      steps_q      <= '0;
      words_seen_q <= '0;
      first_bad_q  <= 16'hFFFF;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
      success_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      steps_q      <= steps_d;
      words_seen_q <= words_seen_d;
      first_bad_q  <= first_bad_d;
      mismatch_q   <= mismatch_d;
      timeout_q    <= timeout_d;
      success_q    <= success_d;
    end
  end

  assign finished_o   = (state_q == StDone);
  assign success_o    = success_q;
  assign mismatch_o   = mismatch_q;
  assign timeout_o    = timeout_q;
  assign words_seen_o = words_seen_q;
  assign first_bad_o  = first_bad_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Self-checking bench for out_channel_checker: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_out_channel_checker;
  localparam int W     = 12;
  localparam int NExp  = 4;
  localparam int Depth = 4;
  localparam int MS    = 1000;

  logic         clk, rst_n, exp_we, start, in_valid, hold, prog_finished;
  logic [7:0]   exp_addr;
  logic [W-1:0] exp_data, in_data;
  logic         in_ready, finished, success, mismatch, timeout;
  logic [15:0]  words_seen, first_bad;
  logic         to_in_ready, to_finished, to_success, to_mismatch, to_timeout;
  logic [15:0]  to_words_seen, to_first_bad;

  int errors = 0;
  int checks = 0;

  out_channel_checker #(
    .MemoryElementWidth(W), .NExpected(NExp), .Depth(Depth), .MaxSteps(MS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .exp_we_i(exp_we), .exp_addr_i(exp_addr),
    .exp_data_i(exp_data), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .hold_i(hold), .prog_finished_i(prog_finished),
    .finished_o(finished), .success_o(success), .mismatch_o(mismatch),
    .timeout_o(timeout), .words_seen_o(words_seen), .first_bad_o(first_bad)
  );

  // Short step budget instance for the timeout scenario; shares all inputs.
  out_channel_checker #(
    .MemoryElementWidth(W), .NExpected(NExp), .Depth(Depth), .MaxSteps(20)
  ) dut_to (
    .clk_i(clk), .rst_ni(rst_n), .exp_we_i(exp_we), .exp_addr_i(exp_addr),
    .exp_data_i(exp_data), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(to_in_ready), .hold_i(hold), .prog_finished_i(prog_finished),
    .finished_o(to_finished), .success_o(to_success), .mismatch_o(to_mismatch),
    .timeout_o(to_timeout), .words_seen_o(to_words_seen), .first_bad_o(to_first_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct {
    string        name;
    int           n;
    logic [W-1:0] w [6];
    logic [15:0]  seen;
    logic         mm;
    logic [15:0]  fb;
    logic         succ;
  } vec_t;

  vec_t         tbl [6];
  logic [W-1:0] exp_ref [NExp];

  // Reference model state
  bit           m_run, m_fin, m_mm, m_to, m_succ;
  int           m_seen, m_fb, m_steps;
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_exp [NExp];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_we = 0; exp_addr = '0; exp_data = '0; start = 0;
    in_valid = 0; in_data = '0; hold = 0; prog_finished = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // Loads exp_ref, then tries out-of-range writes that must not alias index 0.
  task automatic load_exp();
    for (int i = 0; i < NExp; i++) begin
      exp_we = 1; exp_addr = 8'(i); exp_data = exp_ref[i];
      step();
    end
    exp_addr = 8'(NExp); exp_data = ~exp_ref[0];
    step();
    exp_addr = 8'h80; exp_data = ~exp_ref[0];
    step();
    exp_we = 0;
  endtask

  task automatic start_run();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    bit acc;
    acc = 0;
    in_valid = 1;
    in_data  = w;
    for (int t = 0; t < 50; t++) begin
      acc = in_ready;
      step();
      if (acc) break;
    end
    in_valid = 0;
    if (!acc) fail_now("push_word");
  endtask

  task automatic wait_finished(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (finished) break;
      step();
    end
    check("finished", 32'(finished), 32'd1);
  endtask

  function automatic bit model_ready();
    return m_run && (m_q.size() < Depth);
  endfunction

  task automatic model_cycle(input bit v, input logic [W-1:0] d, input bit h, input bit pf,
                             output bit pushed_o);
    bit           was_empty, popping, bad;
    logic [W-1:0] w;
    pushed_o = 0;
    if (m_run) begin
      was_empty = (m_q.size() == 0);
      pushed_o  = v && (m_q.size() < Depth);
      popping   = !was_empty && !h;
      if (popping) begin
        w = m_q.pop_front();
        if (m_seen >= NExp) bad = 1;
        else bad = (w != m_exp[m_seen]);
        if (bad && !m_mm) begin
          m_mm = 1;
          m_fb = m_seen;
        end
        m_seen++;
      end
      if (pushed_o) m_q.push_back(d);
      m_steps++;
      if (pf && was_empty) begin
        m_run = 0; m_fin = 1;
      end else if (m_steps == MS) begin
        m_run = 0; m_fin = 1; m_to = 1;
      end
      if (m_fin) m_succ = !m_mm && !m_to && (m_seen == NExp);
    end
  endtask

  initial begin
    tbl[0].name = "pass";      tbl[0].n = 4; tbl[0].w = '{2, 5, 7, 9, 0, 0};
    tbl[0].seen = 4; tbl[0].mm = 0; tbl[0].fb = 16'hFFFF; tbl[0].succ = 1;
    tbl[1].name = "wrong1";    tbl[1].n = 4; tbl[1].w = '{2, 6, 7, 9, 0, 0};
    tbl[1].seen = 4; tbl[1].mm = 1; tbl[1].fb = 1; tbl[1].succ = 0;
    tbl[2].name = "short";     tbl[2].n = 3; tbl[2].w = '{2, 5, 7, 0, 0, 0};
    tbl[2].seen = 3; tbl[2].mm = 0; tbl[2].fb = 16'hFFFF; tbl[2].succ = 0;
    tbl[3].name = "surplus";   tbl[3].n = 5; tbl[3].w = '{2, 5, 7, 9, 3, 0};
    tbl[3].seen = 5; tbl[3].mm = 1; tbl[3].fb = 4; tbl[3].succ = 0;
    tbl[4].name = "wrong0";    tbl[4].n = 4; tbl[4].w = '{3, 5, 7, 9, 0, 0};
    tbl[4].seen = 4; tbl[4].mm = 1; tbl[4].fb = 0; tbl[4].succ = 0;
    tbl[5].name = "wrong3";    tbl[5].n = 4; tbl[5].w = '{2, 5, 7, 8, 0, 0};
    tbl[5].seen = 4; tbl[5].mm = 1; tbl[5].fb = 3; tbl[5].succ = 0;

    // Reset values, LOAD behaviour and start latency
    do_reset();
    rst_n = 0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_success", 32'(success), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_words_seen", 32'(words_seen), 32'd0);
    check("rst_first_bad", 32'(first_bad), 32'hFFFF);
    rst_n = 1;
    exp_ref = '{12'd2, 12'd5, 12'd7, 12'd9};
    load_exp();
    in_valid = 1;
    step();
    check("load_in_ready", 32'(in_ready), 32'd0);
    in_valid = 0;
    start = 1;
    check("start_same_cycle_ready", 32'(in_ready), 32'd0);
    step();
    start = 0;
    check("start_next_ready", 32'(in_ready), 32'd1);

    // Table-driven end-to-end vectors
    foreach (tbl[i]) begin
      do_reset();
      exp_ref = '{12'd2, 12'd5, 12'd7, 12'd9};
      load_exp();
      start_run();
      for (int k = 0; k < tbl[i].n; k++) push_word(tbl[i].w[k]);
      prog_finished = 1;
      wait_finished(20);
      check({tbl[i].name, "_seen"}, 32'(words_seen), 32'(tbl[i].seen));
      check({tbl[i].name, "_mismatch"}, 32'(mismatch), 32'(tbl[i].mm));
      check({tbl[i].name, "_first_bad"}, 32'(first_bad), 32'(tbl[i].fb));
      check({tbl[i].name, "_success"}, 32'(success), 32'(tbl[i].succ));
      check({tbl[i].name, "_timeout"}, 32'(timeout), 32'd0);
      in_valid = 1;
      step();
      check({tbl[i].name, "_done_ready"}, 32'(in_ready), 32'd0);
      in_valid = 0;
    end

    // Mismatch timing: visible right after the edge that pops the bad word
    do_reset();
    load_exp();
    start_run();
    in_valid = 1; in_data = 12'd2;
    step();
    in_data = 12'd6;
    step();
    check("wrong_before_pop", 32'(mismatch), 32'd0);
    in_data = 12'd7;
    step();
    check("wrong_after_pop", 32'(mismatch), 32'd1);
    check("wrong_first_bad", 32'(first_bad), 32'd1);
    check("wrong_seen", 32'(words_seen), 32'd2);
    in_valid = 0;

    // Backpressure: hold pop, fill FIFO, then drain six words in order
    begin
      logic [W-1:0] bw [6];
      int           idx;
      bit           acc;
      bw = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h055, 12'h066};
      do_reset();
      exp_ref = '{12'h011, 12'h022, 12'h033, 12'h044};
      load_exp();
      start_run();
      hold = 1; in_valid = 1; idx = 0;
      for (int t = 0; t < 8; t++) begin
        in_data = bw[idx];
        acc = in_ready;
        step();
        if (acc) idx++;
      end
      check("bp_accepted_while_held", 32'(idx), 32'd4);
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check("bp_seen_held", 32'(words_seen), 32'd0);
      hold = 0;
      in_data = bw[idx];
      check("bp_no_lookahead", 32'(in_ready), 32'd0);
      for (int t = 0; t < 20 && idx < 6; t++) begin
        in_data = bw[idx];
        acc = in_ready;
        step();
        if (acc) idx++;
      end
      in_valid = 0;
      if (idx != 6) fail_now("bp_drain");
      prog_finished = 1;
      wait_finished(20);
      check("bp_seen", 32'(words_seen), 32'd6);
      check("bp_first_bad", 32'(first_bad), 32'd4);
      check("bp_success", 32'(success), 32'd0);
    end

    // Timeout on the MaxSteps=20 instance
    do_reset();
    exp_ref = '{12'd2, 12'd5, 12'd7, 12'd9};
    load_exp();
    start_run();
    repeat (19) step();
    check("to_not_yet", 32'(to_finished), 32'd0);
    step();
    check("to_finished", 32'(to_finished), 32'd1);
    check("to_timeout", 32'(to_timeout), 32'd1);
    check("to_success", 32'(to_success), 32'd0);
    check("to_main_running", 32'(finished), 32'd0);

    // Asynchronous reset mid-RUN, then rerun reusing the old expected vector
    do_reset();
    load_exp();
    start_run();
    push_word(12'd3);
    push_word(12'd5);
    step();
    check("ar_pre_mismatch", 32'(mismatch), 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_mismatch", 32'(mismatch), 32'd0);
    check("ar_seen", 32'(words_seen), 32'd0);
    check("ar_first_bad", 32'(first_bad), 32'hFFFF);
    step();
    rst_n = 1;
    start_run();
    push_word(12'd2); push_word(12'd5); push_word(12'd7); push_word(12'd9);
    prog_finished = 1;
    wait_finished(20);
    check("ar_rerun_success", 32'(success), 32'd1);
    check("ar_rerun_seen", 32'(words_seen), 32'd4);

    // Randomized runs against the reference model
    for (int it = 0; it < 12; it++) begin
      int           nwords, pushed, cyc;
      bit           v, h, pf, pd;
      logic [W-1:0] d;
      do_reset();
      for (int i = 0; i < NExp; i++) exp_ref[i] = W'($urandom);
      load_exp();
      m_exp = exp_ref;
      m_q.delete();
      m_run = 0; m_fin = 0; m_mm = 0; m_to = 0; m_succ = 0;
      m_seen = 0; m_fb = 16'hFFFF; m_steps = 0;
      start_run();
      m_run = 1;
      nwords = $urandom_range(2, 6);
      pushed = 0;
      cyc = 0;
      while (!m_fin && cyc < 300) begin
        v  = (pushed < nwords) && ($urandom_range(0, 3) != 0);
        d  = (pushed < NExp && $urandom_range(0, 9) != 0) ? exp_ref[pushed] : W'($urandom);
        h  = ($urandom_range(0, 2) == 0);
        pf = (pushed >= nwords) && ($urandom_range(0, 1) == 1);
        in_valid = v; in_data = d; hold = h; prog_finished = pf;
        exp_we   = ($urandom_range(0, 3) == 0);
        exp_addr = 8'($urandom_range(0, NExp - 1));
        exp_data = ~exp_ref[exp_addr];
        start    = ($urandom_range(0, 7) == 0);
        model_cycle(v, d, h, pf, pd);
        if (pd) pushed++;
        step();
        cyc++;
        check("rnd_in_ready", 32'(in_ready), 32'(model_ready()));
        check("rnd_finished", 32'(finished), 32'(m_fin));
        check("rnd_success", 32'(success), 32'(m_succ));
        check("rnd_mismatch", 32'(mismatch), 32'(m_mm));
        check("rnd_words_seen", 32'(words_seen), 32'(m_seen));
        check("rnd_first_bad", 32'(first_bad), 32'(m_fb));
      end
      exp_we = 0; start = 0; in_valid = 0; hold = 0; prog_finished = 0;
      if (!m_fin) fail_now("rnd_model_finish");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
